// File: rtl/cnn_layer1_reader_if.sv
// Read-port and output-stream bundle between layer 1, this reader and layer 2.
// The master side belongs to the reader: it drives read requests and stream beats.
interface cnn_layer1_reader_if #(
    parameter int DW = 24,
    parameter int AW = 8
) ();
    logic          RD_EN;
    logic [AW-1:0] RD_ADDR;
    logic          RD_VALID;
    logic [DW-1:0] RD_DATA0;
    logic [DW-1:0] RD_DATA1;
    logic [DW-1:0] RD_DATA2;
    logic [DW-1:0] RD_DATA3;

    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA0;
    logic [DW-1:0] OUT_DATA1;
    logic [DW-1:0] OUT_DATA2;
    logic [DW-1:0] OUT_DATA3;
    logic          OUT_LAST_IN_LINE;
    logic          OUT_LAST_PIX;

    modport master (
        output RD_EN, RD_ADDR,
        input  RD_VALID, RD_DATA0, RD_DATA1, RD_DATA2, RD_DATA3,
        output OUT_VALID, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3,
        output OUT_LAST_IN_LINE, OUT_LAST_PIX,
        input  OUT_READY
    );

    modport slave (
        input  RD_EN, RD_ADDR,
        output RD_VALID, RD_DATA0, RD_DATA1, RD_DATA2, RD_DATA3,
        input  OUT_VALID, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3,
        input  OUT_LAST_IN_LINE, OUT_LAST_PIX,
        output OUT_READY
    );
endinterface

// File: rtl/cnn_layer1_reader.sv
// Streams the layer-1 result buffer to layer 2 in raster order once layer 1 is
// finished; reads are credit-limited so the small output FIFO can never overflow.
module cnn_layer1_reader #(
    parameter int DW         = 24,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic START,
    input  logic L1_FINISHED,
    cnn_layer1_reader_if.master bus,
    output logic BUSY,
    output logic DONE,
    output logic PROTO_ERR
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int CLW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int EW   = 4 * DW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIN,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [AW-1:0]  r_addr;
    logic [CLW-1:0] r_col;
    logic           r_rd_en;
    logic [AW-1:0]  r_rd_addr;
    logic           r_iss_line;
    logic           r_iss_last;
    logic           r_tp_line;
    logic           r_tp_last;
    logic [CW-1:0]  r_in_flight;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [EW-1:0]  r_mem [FIFO_DEPTH];
    logic           r_proto_err;

    logic           w_abort;
    logic           w_start_ok;
    logic           w_credit_ok;
    logic           w_issue;
    logic           w_last_addr;
    logic           w_line_end;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_out_valid;
    logic [EW-1:0]  w_wr_word;
    logic [EW-1:0]  w_head;

    // Losing L1_FINISHED mid-readout means the buffer may be rewritten: abandon everything.
    assign w_abort     = ((r_state == S_FETCH) || (r_state == S_DRAIN)) && !L1_FINISHED;
    assign w_start_ok  = START && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_in_flight}) < (CW + 1)'(FIFO_DEPTH);
    assign w_issue     = (r_state == S_FETCH) && !w_abort && w_credit_ok;
    assign w_last_addr = (r_addr == AW'(NPIX - 1));
    assign w_line_end  = (r_col == CLW'(IMG_W - 1));

    assign w_drop      = bus.RD_VALID && (r_in_flight == '0);
    assign w_push      = bus.RD_VALID && (r_in_flight != '0) && !w_abort;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.OUT_READY;
    assign w_wr_word   = {r_tp_line, r_tp_last,
                          bus.RD_DATA3, bus.RD_DATA2, bus.RD_DATA1, bus.RD_DATA0};

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) w_state_next = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (L1_FINISHED) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_abort)                   w_state_next = S_WAIT_FIN;
                else if (w_issue && w_last_addr) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_abort)
                    w_state_next = S_WAIT_FIN;
                else if ((r_count == '0) && (r_in_flight == '0))
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address/column counters and the registered read request with its tags.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_addr     <= '0;
            r_col      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_iss_line <= 1'b0;
            r_iss_last <= 1'b0;
            r_tp_line  <= 1'b0;
            r_tp_last  <= 1'b0;
        end else begin
            r_rd_en <= w_issue;
            if (w_start_ok || w_abort) begin
                r_addr <= '0;
                r_col  <= '0;
            end else if (w_issue) begin
                if (!w_last_addr) r_addr <= r_addr + AW'(1);
                r_col <= w_line_end ? '0 : r_col + CLW'(1);
            end
            if (w_issue) begin
                r_rd_addr  <= r_addr;
                r_iss_line <= w_line_end;
                r_iss_last <= w_last_addr;
            end
            // Tags wait one more cycle so they line up with RD_VALID.
            if (r_rd_en) begin
                r_tp_line <= r_iss_line;
                r_tp_last <= r_iss_last;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn || w_abort) begin
            r_in_flight <= '0;
        end else begin
            r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_push);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn || w_abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= w_wr_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_proto_err <= 1'b0;
        end else if (w_abort || w_drop) begin
            r_proto_err <= 1'b1;
        end
    end

    // Head word is forced to zero when empty so idle outputs stay quiet.
    assign w_head = w_out_valid ? r_mem[r_rptr] : '0;

    assign bus.RD_EN            = r_rd_en;
    assign bus.RD_ADDR          = r_rd_addr;
    assign bus.OUT_VALID        = w_out_valid;
    assign bus.OUT_DATA0        = w_head[0*DW +: DW];
    assign bus.OUT_DATA1        = w_head[1*DW +: DW];
    assign bus.OUT_DATA2        = w_head[2*DW +: DW];
    assign bus.OUT_DATA3        = w_head[3*DW +: DW];
    assign bus.OUT_LAST_PIX     = w_head[4*DW];
    assign bus.OUT_LAST_IN_LINE = w_head[4*DW+1];

    assign BUSY      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign DONE      = (r_state == S_DONE);
    assign PROTO_ERR = r_proto_err;
endmodule

// File: tb/tb_cnn_layer1_reader.sv
// Directed bench: a layer-1 memory model with 1-cycle latency, a raster-order
// scoreboard with stall and credit checks, table-driven frames and corner sequences.
module tb_cnn_layer1_reader;
    localparam int DW    = 24;
    localparam int AW    = 8;
    localparam int IMG_W = 16;
    localparam int NPIX  = 256;

    logic CLK = 1'b0;
    logic RSTn, START, L1_FINISHED;
    logic BUSY, DONE, PROTO_ERR;

    always #5 CLK = ~CLK;

    cnn_layer1_reader_if #(.DW(DW), .AW(AW)) bus ();

    cnn_layer1_reader #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(16), .AW(AW), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .L1_FINISHED(L1_FINISHED),
        .bus(bus), .BUSY(BUSY), .DONE(DONE), .PROTO_ERR(PROTO_ERR)
    );

    typedef struct {
        int ready_pct;
        int max_cycles;
        int exp_beats;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t          vecs [3];
    int            tests = 0;
    int            fails = 0;
    int            ready_pct = 100;
    int            exp_idx, issued, accepted;
    bit            mon_on = 1'b0;
    bit            inject = 1'b0;
    bit            prev_stall;
    logic [97:0]   prev_word;
    logic          pend_en = 1'b0;
    logic [AW-1:0] pend_ad = '0;

    function automatic logic [DW-1:0] pix(input int a, input int k);
        return {8'(k + 1), 8'(a * 3 + k), 8'(a)};
    endfunction

    function automatic logic [97:0] exp_word(input int a);
        logic ll, lp;
        ll = ((a % IMG_W) == IMG_W - 1);
        lp = (a == NPIX - 1);
        return {ll, lp, pix(a, 3), pix(a, 2), pix(a, 1), pix(a, 0)};
    endfunction

    function automatic logic [97:0] out_word();
        return {bus.OUT_LAST_IN_LINE, bus.OUT_LAST_PIX,
                bus.OUT_DATA3, bus.OUT_DATA2, bus.OUT_DATA1, bus.OUT_DATA0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        exp_idx = 0; issued = 0; accepted = 0; prev_stall = 1'b0;
    endtask

    // One clock: memory model answers last cycle's read, ready is driven, then monitor.
    task automatic tick();
        logic en;
        @(posedge CLK);
        en = pend_en && RSTn;
        #1;
        bus.RD_VALID  = en || inject;
        bus.RD_DATA0  = en ? pix(int'(pend_ad), 0) : '0;
        bus.RD_DATA1  = en ? pix(int'(pend_ad), 1) : '0;
        bus.RD_DATA2  = en ? pix(int'(pend_ad), 2) : '0;
        bus.RD_DATA3  = en ? pix(int'(pend_ad), 3) : '0;
        bus.OUT_READY = ($urandom_range(0, 99) < ready_pct);
        @(negedge CLK);
        pend_en = bus.RD_EN;
        pend_ad = bus.RD_ADDR;
        if (mon_on) begin
            if (bus.RD_EN) begin
                issued++;
                check("credit", 128'((issued - accepted) <= 4), 128'(1));
            end
            if (prev_stall)
                check("stall_hold", {bus.OUT_VALID, out_word()}, {1'b1, prev_word});
            if (bus.OUT_VALID && bus.OUT_READY) begin
                check("beat_range", 128'(exp_idx < NPIX), 128'(1));
                check("beat_data", out_word(), exp_word(exp_idx));
                exp_idx++;
                accepted++;
            end
            prev_stall = bus.OUT_VALID && !bus.OUT_READY;
            prev_word  = out_word();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {bus.RD_EN, bus.RD_ADDR, bus.OUT_VALID, BUSY, DONE, PROTO_ERR}, '0);
        check({name, "_data"}, out_word(), '0);
    endtask

    task automatic do_reset(input bit check_it);
        mon_on = 1'b0; START = 1'b0; L1_FINISHED = 1'b0; inject = 1'b0;
        RSTn = 1'b0;
        tick();
        tick();
        if (check_it) check_reset_outputs("reset");
        RSTn = 1'b1;
        mon_clear();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic run_to_done(input string name, input int budget, output int n);
        n = 0;
        while (!DONE && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done"}, 128'(DONE), 128'(1));
    endtask

    task automatic wait_addr(input int a);
        bit ok = 1'b0;
        int n = 0;
        while (!ok && n < 2000) begin
            tick();
            n++;
            if (bus.RD_EN && bus.RD_ADDR == AW'(a)) ok = 1'b1;
        end
        check("wait_addr", 128'(ok), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit flag, flag2;
        vecs[0] = '{100, 264, 256, 1'b1, 1'b0};
        vecs[1] = '{50, 3000, 256, 1'b1, 1'b0};
        vecs[2] = '{30, 3000, 256, 1'b1, 1'b0};

        RSTn = 1'b0; START = 1'b0; L1_FINISHED = 1'b0;
        bus.RD_VALID = 1'b0; bus.OUT_READY = 1'b0;
        bus.RD_DATA0 = '0; bus.RD_DATA1 = '0; bus.RD_DATA2 = '0; bus.RD_DATA3 = '0;

        do_reset(1'b1);

        for (int vi = 0; vi < 3; vi++) begin
            do_reset(1'b0);
            ready_pct = vecs[vi].ready_pct;
            L1_FINISHED = 1'b1;
            mon_on = 1'b1;
            pulse_start();
            run_to_done("frame", 3000, n);
            check("frame_cycles", 128'(n <= vecs[vi].max_cycles), 128'(1));
            repeat (3) tick();
            check("frame_beats", 128'(exp_idx), 128'(vecs[vi].exp_beats));
            check("frame_flags", {DONE, PROTO_ERR, BUSY},
                  {vecs[vi].exp_done, vecs[vi].exp_err, 1'b0});
            $display("[TB] frame vec=%0d ready=%0d%% beats=%0d cycles=%0d", vi, ready_pct, exp_idx, n);
        end

        // Waiting for layer 1, then the first request/beat latency.
        do_reset(1'b0);
        ready_pct = 100; mon_on = 1'b1;
        pulse_start();
        flag = 1'b0; flag2 = 1'b1;
        repeat (20) begin
            tick();
            if (bus.RD_EN) flag = 1'b1;
            if (!BUSY) flag2 = 1'b0;
        end
        check("wait_no_rden", 128'(flag), 128'(0));
        check("wait_busy", 128'(flag2), 128'(1));
        L1_FINISHED = 1'b1;
        tick();
        check("fetch_entry_rden", 128'(bus.RD_EN), 128'(0));
        tick();
        check("first_rden", {bus.RD_EN, bus.RD_ADDR}, {1'b1, 8'd0});
        tick();
        check("first_ov_c1", 128'(bus.OUT_VALID), 128'(0));
        tick();
        check("first_ov_c2", 128'(bus.OUT_VALID), 128'(1));
        run_to_done("late_fin", 3000, n);
        check("late_fin_beats", {128'(exp_idx)}, 128'(NPIX));
        $display("[TB] late-finish frame beats=%0d", exp_idx);

        // L1_FINISHED dropped after the read of address 100.
        do_reset(1'b0);
        ready_pct = 100; L1_FINISHED = 1'b1; mon_on = 1'b1;
        pulse_start();
        wait_addr(100);
        mon_clear();
        L1_FINISHED = 1'b0;
        tick();
        check("abort_outs", {bus.OUT_VALID, bus.RD_EN, PROTO_ERR, BUSY, DONE}, 5'b00110);
        flag = 1'b0;
        repeat (3) begin
            tick();
            if (bus.RD_EN || bus.OUT_VALID || !BUSY) flag = 1'b1;
        end
        check("abort_hold_wait", 128'(flag), 128'(0));
        L1_FINISHED = 1'b1;
        run_to_done("abort_restart", 3000, n);
        check("abort_restart_beats", 128'(exp_idx), 128'(NPIX));
        check("abort_err_sticky", 128'(PROTO_ERR), 128'(1));
        $display("[TB] abort at addr 100 then restart beats=%0d", exp_idx);

        // One-cycle reset in the middle of FETCH.
        do_reset(1'b0);
        ready_pct = 100; L1_FINISHED = 1'b1; mon_on = 1'b1;
        pulse_start();
        wait_addr(50);
        RSTn = 1'b0;
        tick();
        check_reset_outputs("midreset");
        RSTn = 1'b1;
        mon_clear();
        repeat (2) tick();
        check("midreset_idle", {BUSY, DONE, PROTO_ERR, bus.OUT_VALID, bus.RD_EN}, '0);
        pulse_start();
        run_to_done("midreset_frame", 3000, n);
        check("midreset_beats", 128'(exp_idx), 128'(NPIX));
        check("midreset_err", 128'(PROTO_ERR), 128'(0));
        $display("[TB] mid-frame reset then new frame beats=%0d", exp_idx);

        // Unsolicited RD_VALID while idle.
        do_reset(1'b0);
        mon_on = 1'b1;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("stray_ov0", 128'(bus.OUT_VALID), 128'(0));
        tick();
        check("stray_err", {PROTO_ERR, bus.OUT_VALID, BUSY}, 3'b100);
        flag = 1'b0;
        repeat (3) begin
            tick();
            if (bus.OUT_VALID) flag = 1'b1;
        end
        check("stray_no_beat", {128'(flag)}, 128'(0));
        $display("[TB] stray RD_VALID in idle proto_err=%0b", PROTO_ERR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
